// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches over a req/ready + rvalid handshake, applies redirects.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned redirect targets into a HALT state.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [2:0]  pc_sel,
    output logic        misalign
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;
`endif

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [2:0]  sel_n;
    logic        capture;
    logic        redirect;
    logic        bad_target;
    logic        accept;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [2:0]  redir_sel;

    assign redirect   = jump | (branch & branch_taken);
    assign target_raw = jump ? jump_target : branch_target;
    assign redir_sel  = jump ? 3'b100 : 3'b011;

`ifdef MISALIGN_TRAP_EN
    assign target     = target_raw;
    assign bad_target = redirect & (target_raw[1:0] != 2'b00);
`else
    assign target     = target_raw & 32'hFFFF_FFFC;
    assign bad_target = 1'b0;
`endif

    // Request is suppressed while reset is held so the port reads idle during reset.
    assign imem_req  = (state == S_REQ) & ~stall & ~reset;
    assign imem_addr = pc;
    assign accept    = imem_req & imem_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_n = state;
        pc_n    = pc;
        sel_n   = pc_sel;
        capture = 1'b0;

        if (redirect) begin
            pc_n  = target;
            sel_n = redir_sel;
        end else if (branch) begin
            sel_n = 3'b010;
        end

        case (state)
            S_REQ: begin
                if (accept) state_n = redirect ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    // A response landing with the redirect is stale; nothing remains in flight.
                    state_n = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    capture = 1'b1;
                    pc_n    = pc + 32'd4;
                    sel_n   = 3'b000;
                    state_n = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) state_n = S_REQ;
            end
            default: state_n = S_REQ;
        endcase

`ifdef MISALIGN_TRAP_EN
        if (state == S_HALT) begin
            state_n = S_HALT;
            pc_n    = pc;
            sel_n   = pc_sel;
        end else if (bad_target) begin
            state_n = S_HALT;
            pc_n    = pc;
            sel_n   = pc_sel;
            capture = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            pc_sel      <= 3'b000;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pc_sel      <= sel_n;
            instr_valid <= capture;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clock) begin
        if (reset) misalign <= 1'b0;
        else       misalign <= bad_target & (state != S_HALT);
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl; honours MISALIGN_TRAP_EN for the trap scenario.
module tb_pc_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  pc_sel;
    logic        misalign;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch(branch), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .pc_sel(pc_sel), .misalign(misalign)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; branch = 0; branch_taken = 0; branch_target = 0;
        jump = 0; jump_target = 0; imem_ready = 1; imem_rvalid = 0; imem_rdata = 0;
    endtask

    // One full fetch from REQ at address a: accept, then rvalid the following cycle.
    task automatic fetch_one(input logic [31:0] a);
        logic [31:0] d;
        d = a ^ 32'hA5A5_A5A5;
        #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req@%h got=%b exp=1", a, imem_req); end
        n_cmp++; if (imem_addr !== a) begin n_fail++; $display("FAIL fetch_addr got=%h exp=%h", imem_addr, a); end
        cycle();
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wait_req@%h got=%b exp=0", a, imem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid@%h got=%b exp=0", a, instr_valid); end
        imem_rvalid = 1; imem_rdata = d;
        cycle();
        imem_rvalid = 0; imem_rdata = 0;
        #1;
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL instr_valid@%h got=%b exp=1", a, instr_valid); end
        n_cmp++; if (instr_pc !== a) begin n_fail++; $display("FAIL instr_pc got=%h exp=%h", instr_pc, a); end
        n_cmp++; if (instr !== d) begin n_fail++; $display("FAIL instr@%h got=%h exp=%h", a, instr, d); end
        n_cmp++; if (pc_sel !== 3'b000) begin n_fail++; $display("FAIL seq_pc_sel@%h got=%b exp=000", a, pc_sel); end
        n_cmp++; if (imem_addr !== a + 32'd4) begin n_fail++; $display("FAIL next_addr got=%h exp=%h", imem_addr, a + 32'd4); end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        cycle(); cycle();
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
        n_cmp++; if (pc_sel !== 3'b000) begin n_fail++; $display("FAIL rst_pc_sel got=%b exp=000", pc_sel); end
        n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got=%b exp=0", misalign); end
        reset = 0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) fetch_one(32'(i * 4));
    endtask

    task automatic test_jump_wait();
        // PC is 0x10 in REQ: accept, then jump during WAIT with no response yet.
        fetch_one(32'h10);
        cycle();
        jump = 1; jump_target = 32'h100;
        cycle();
        jump = 0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_req got=%b exp=0", imem_req); end
        n_cmp++; if (pc_sel !== 3'b100) begin n_fail++; $display("FAIL jump_pc_sel got=%b exp=100", pc_sel); end
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        imem_rvalid = 0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL discard_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL post_drain_req got=%b exp=1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL jump_addr got=%h exp=100", imem_addr); end
    endtask

    task automatic test_branch();
        // Not-taken branch during the accept cycle: pc_sel 010, fetch continues normally.
        branch = 1; branch_taken = 0; branch_target = 32'h999C;
        cycle();
        branch = 0;
        #1;
        n_cmp++; if (pc_sel !== 3'b010) begin n_fail++; $display("FAIL nt_pc_sel got=%b exp=010", pc_sel); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL nt_addr got=%h exp=100", imem_addr); end
        imem_rvalid = 1; imem_rdata = 32'h1234_5678;
        cycle();
        imem_rvalid = 0;
        #1;
        n_cmp++; if (instr_pc !== 32'h100) begin n_fail++; $display("FAIL nt_instr_pc got=%h exp=100", instr_pc); end
        n_cmp++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL nt_next_addr got=%h exp=104", imem_addr); end
        // Taken branch while stalled in REQ.
        stall = 1; branch = 1; branch_taken = 1; branch_target = 32'h40;
        cycle();
        branch = 0; branch_taken = 0;
        #1;
        n_cmp++; if (pc_sel !== 3'b011) begin n_fail++; $display("FAIL tk_pc_sel got=%b exp=011", pc_sel); end
        n_cmp++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL tk_addr got=%h exp=40", imem_addr); end
        stall = 0;
    endtask

    task automatic test_priority_accept();
        // Jump and taken branch on the accept cycle: jump wins, outstanding fetch is drained.
        jump = 1; jump_target = 32'h200;
        branch = 1; branch_taken = 1; branch_target = 32'h300;
        cycle();
        jump = 0; branch = 0; branch_taken = 0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL prio_drain_req got=%b exp=0", imem_req); end
        n_cmp++; if (pc_sel !== 3'b100) begin n_fail++; $display("FAIL prio_pc_sel got=%b exp=100", pc_sel); end
        imem_rvalid = 1;
        cycle();
        imem_rvalid = 0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL prio_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL prio_addr got=%h exp=200", imem_addr); end
        // Redirect coinciding with rvalid in WAIT: response dropped, straight back to REQ.
        cycle();
        imem_rvalid = 1; imem_rdata = 32'hCAFE_0000;
        branch = 1; branch_taken = 1; branch_target = 32'h80;
        cycle();
        imem_rvalid = 0; branch = 0; branch_taken = 0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wr_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wr_req got=%b exp=1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h80) begin n_fail++; $display("FAIL wr_addr got=%h exp=80", imem_addr); end
        n_cmp++; if (pc_sel !== 3'b011) begin n_fail++; $display("FAIL wr_pc_sel got=%b exp=011", pc_sel); end
    endtask

    task automatic test_stall_wrap();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d] got=%b exp=0", i, imem_req); end
            cycle();
        end
        stall = 0;
        fetch_one(32'h80);
        stall = 1; jump = 1; jump_target = 32'hFFFF_FFFC;
        cycle();
        stall = 0; jump = 0;
        fetch_one(32'hFFFF_FFFC);
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_reset_mid();
        // 0x0 fetch accepted, reset while waiting, then a stale rvalid must be ignored.
        cycle();
        reset = 1;
        cycle();
        reset = 0; stall = 1; imem_rvalid = 1; imem_rdata = 32'h5555_AAAA;
        cycle();
        imem_rvalid = 0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_addr got=%h exp=0", imem_addr); end
        stall = 0;
        fetch_one(32'h0);
    endtask

    task automatic test_misalign();
        stall = 1; jump = 1; jump_target = 32'h102;
        cycle();
        jump = 0; stall = 0;
        #1;
`ifdef MISALIGN_TRAP_EN
        n_cmp++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got=%b exp=1", misalign); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req[%0d] got=%b exp=0", i, imem_req); end
            cycle();
            n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_low[%0d] got=%b exp=0", i, misalign); end
        end
        reset = 1;
        cycle();
        reset = 0;
        #1;
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL halt_rst_addr got=%h exp=0", imem_addr); end
        fetch_one(32'h0);
`else
        n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_tied got=%b exp=0", misalign); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL mis_forced_addr got=%h exp=100", imem_addr); end
        fetch_one(32'h100);
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_wait();
        test_branch();
        test_priority_accept();
        test_stall_wrap();
        test_reset_mid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Instruction-fetch controller that owns the program counter, issues fetch requests to instruction memory over a request/response handshake, and applies redirects from execute. It produces the 3-bit next-PC selection code consumed by the 32-bit PC selection mux (00x sequential, 01x conditional branch with bit0 = taken, 10x jump, 11x forced branch). It sits between the execute stage and instruction memory, at the front of the fetch pipeline.

## Interface
- RESET_PC, 32'h00000000, PC loaded on reset; must be word-aligned.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  pipeline hazard; blocks issue of new fetch requests.
- branch  input  1  branch resolved this cycle.
- branch_taken  input  1  branch outcome; valid only when branch=1.
- branch_target  input  32  branch destination.
- jump  input  1  unconditional jump this cycle.
- jump_target  input  32  jump destination.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address (current PC).
- imem_ready  input  1  memory accepts request when imem_req=1.
- imem_rvalid  input  1  fetch response valid.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  one-cycle pulse, fetched instruction available.
- instr  output  32  fetched instruction.
- instr_pc  output  32  address of instr.
- pc_sel  output  3  selection code applied at the last PC update.
- misalign  output  1  misaligned-target trap pulse (see Configuration).

## Operation
- States: REQ, WAIT, DRAIN, HALT. Reset → REQ, pc=RESET_PC.
- REQ: imem_req = ~stall; imem_addr = pc. Handshake on imem_req & imem_ready → WAIT.
- WAIT: on imem_rvalid, capture imem_rdata into instr, pc into instr_pc, pulse instr_valid; pc ← pc+4; pc_sel ← 000; → REQ.
- Redirect = jump | (branch & branch_taken). jump has priority over branch when both are asserted. target = jump ? jump_target : branch_target.
- Redirect in REQ (including during the accept cycle): pc ← target; pc_sel ← 100 (jump) or 011 (branch); remain in REQ, or, if the request was accepted in the same cycle, → DRAIN.
- Redirect in WAIT without rvalid: pc ← target; → DRAIN. The in-flight response is discarded.
- Redirect in WAIT with rvalid the same cycle: response discarded (no instr_valid); pc ← target; → REQ.
- DRAIN: imem_req=0. On imem_rvalid, discard the response and → REQ. A redirect in DRAIN overwrites pc/pc_sel and stays in DRAIN.
- branch=1, branch_taken=0: no redirect; pc_sel ← 010; pc is unaffected.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFFFFFC wraps to 0.
- stall does not block response capture or redirects; it only gates imem_req.
- At most one outstanding request at any time.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, pc_sel 000, misalign 0.
- imem_req, imem_addr: combinational from state, pc, and stall.
- instr/instr_pc/instr_valid: registered; rvalid in cycle N produces instr_valid in cycle N+1. imem_req is high again in cycle N+1 if not stalled.
- Minimum 2 cycles per instruction (accept, then rvalid the following cycle).
- Redirect in cycle N: imem_addr = target in cycle N+1, or after the drain completes.
- reset mid-transaction: all state clears the next edge; any later rvalid is ignored until a new request is accepted.

## Configuration
- MISALIGN_TRAP_EN defined: a redirect whose target[1:0]≠00 is not applied. misalign pulses for 1 cycle (registered), the state goes to HALT, and imem_req is held 0 until reset. In-flight responses in HALT are ignored.
- MISALIGN_TRAP_EN undefined: target[1:0] is forced to 00, misalign is tied 0, and the HALT state is removed.

## Test plan
- Reset, RESET_PC=0, imem_ready=1, rvalid one cycle after accept, rdata=addr^32'hA5A5A5A5 → instr_pc sequence 0,4,8,C, instr_valid every 2nd cycle.
- Jump to 32'h100 during WAIT, rvalid one cycle later → no instr_valid for the discarded fetch; next imem_addr=32'h100; pc_sel=100.
- branch=1, taken=0 → pc_sel=010, addresses continue sequentially; branch=1, taken=1, target 32'h40 → pc_sel=011, imem_addr=32'h40.
- jump (target 32'h200) and taken branch (target 32'h300) in the same cycle → imem_addr=32'h200.
- stall held 3 cycles in REQ → imem_req=0 throughout; resumes at the same address; PC at 32'hFFFFFFFC wraps to 0.
- With MISALIGN_TRAP_EN, jump to 32'h102 → misalign pulse, imem_req stays 0 until reset, then fetch restarts at RESET_PC.
